// File: rtl/hazard_ctrl.sv
// Hazard/stall sequencer for the 5-stage pipeline: load-use stall, ID branch flush, mult/div EX occupancy.
// Optional stall performance counter built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
  parameter int unsigned MD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemReadIDEX,
  input  logic [4:0]  RtIDEX,
  input  logic [4:0]  Rs,
  input  logic [4:0]  Rt,
  input  logic        usesRt,
  input  logic        branchTaken,
  input  logic        jump,
  input  logic        mdStart,
  output logic        pcWrite,
  output logic        IFIDWrite,
  output logic        IFIDFlush,
  output logic        bubbleIDEX,
  output logic        busy,
  output logic [15:0] stallCount
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned SC_W  = 16;

  typedef enum logic {IDLE, MD_BUSY} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             load_use;

  assign load_use = MemReadIDEX && (RtIDEX != 5'd0) &&
                    ((RtIDEX == Rs) || (usesRt && (RtIDEX == Rt)));

  // State and occupancy counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state and combinational pipeline controls
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    pcWrite    = 1'b1;
    IFIDWrite  = 1'b1;
    IFIDFlush  = 1'b0;
    bubbleIDEX = 1'b0;
    busy       = 1'b0;
    if (!rst) begin
      pcWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      bubbleIDEX = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (load_use) begin
            // Operands not valid yet, so branch/jump/mdStart wait a cycle
            pcWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            bubbleIDEX = 1'b1;
          end else if (mdStart) begin
            // mdStart beats a simultaneous branch/jump (illegal decode)
            if (MD_CYCLES > 1) begin
              state_nxt = MD_BUSY;
              cnt_nxt   = CNT_W'(MD_CYCLES - 2);
            end
          end else if (branchTaken || jump) begin
            IFIDFlush = 1'b1;
          end
        end
        MD_BUSY: begin
          pcWrite    = 1'b0;
          IFIDWrite  = 1'b0;
          bubbleIDEX = 1'b1;
          busy       = 1'b1;
          if (cnt == '0) begin
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [SC_W-1:0] stall_cnt;

  // Saturating count of bubble cycles
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (bubbleIDEX && (stall_cnt != {SC_W{1'b1}})) begin
      stall_cnt <= stall_cnt + SC_W'(1);
    end
  end

  assign stallCount = stall_cnt;
`else
  assign stallCount = '0;
`endif

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Hazard and stall sequencer for the five-stage MIPS pipeline. It sits beside the IF/ID and ID/EX pipeline registers and decides, every cycle, whether the PC and IF/ID advance, whether IF/ID is flushed, and whether a bubble (all-zero control word) is loaded into ID/EX. It handles three cases:
- load-use hazards;
- taken branches and jumps resolved in ID;
- a multi-cycle mult/div unit that occupies EX for a fixed number of cycles.

## Interface
Parameters:
- MD_CYCLES, 4, EX occupancy of a mult/div instruction in cycles; legal range 1..16.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  synchronous reset, active-low (0 = reset).
- MemReadIDEX  in  1  ID/EX holds a load.
- RtIDEX  in  5  destination register of the instruction in ID/EX.
- Rs  in  5  Rs field of the instruction in ID.
- Rt  in  5  Rt field of the instruction in ID.
- usesRt  in  1  instruction in ID reads Rt as a source.
- branchTaken  in  1  branch in ID resolved taken.
- jump  in  1  jump in ID.
- mdStart  in  1  instruction in ID is mult/div.
- pcWrite  out  1  PC load enable.
- IFIDWrite  out  1  IF/ID load enable.
- IFIDFlush  out  1  clear IF/ID to NOP on the next edge.
- bubbleIDEX  out  1  mux select: zero control fields into ID/EX.
- busy  out  1  mult/div occupancy in progress.
- stallCount  out  16  bubble performance counter.

## Operation
- Load-use condition: loadUse = MemReadIDEX & (RtIDEX != 0) & ((RtIDEX == Rs) | (usesRt & (RtIDEX == Rt))).
- FSM has two states, IDLE and MD_BUSY, and a down-counter cnt of 4 bits.
- IDLE, priority order:
  1. loadUse: pcWrite=0, IFIDWrite=0, bubbleIDEX=1, IFIDFlush=0. branchTaken, jump and mdStart are ignored, because the operands are not valid yet.
  2. mdStart with MD_CYCLES > 1: outputs normal (pcWrite=1, IFIDWrite=1, bubbleIDEX=0). The mult/div enters ID/EX. Next state is MD_BUSY with cnt = MD_CYCLES-2.
  3. mdStart with MD_CYCLES = 1: treated as an ordinary instruction, no state change.
  4. branchTaken or jump: pcWrite=1, IFIDWrite=1, IFIDFlush=1, bubbleIDEX=0.
  5. Otherwise: pcWrite=1, IFIDWrite=1, IFIDFlush=0, bubbleIDEX=0.
- mdStart together with branchTaken/jump is illegal decode. mdStart wins and the flush is suppressed.
- MD_BUSY:
  - Outputs: pcWrite=0, IFIDWrite=0, bubbleIDEX=1, IFIDFlush=0, busy=1. All hazard and branch inputs are ignored.
  - If cnt==0, go to IDLE; otherwise cnt decrements.
- Reset (rst=0 at the edge): state goes to IDLE, cnt=0, stallCount=0.
- While rst is low, outputs are forced combinationally: pcWrite=0, IFIDWrite=0, IFIDFlush=0, bubbleIDEX=1, busy=0.
- Reset asserted during MD_BUSY abandons the occupancy. The first cycle after reset is IDLE.
- stallCount increments on every rising edge where rst=1 and bubbleIDEX=1. It saturates at 16'hFFFF.

## Timing
- Load-use response is combinational, with zero latency. Exactly one stall cycle results, because the inserted bubble clears MemReadIDEX on the next cycle.
- Flush is combinational in the cycle branchTaken/jump is high. Exactly one fetched instruction is squashed.
- mdStart sampled high at edge T: busy=1 and the stall/bubble outputs are active for cycles T+1 .. T+MD_CYCLES-1, i.e. MD_CYCLES-1 cycles. IDLE resumes at T+MD_CYCLES.
- A back-to-back mdStart seen in ID on the first IDLE cycle starts a new occupancy with no gap.
- Only state, cnt and stallCount are registered. All other outputs are a combinational decode of state and inputs.

## Configuration
- HAZARD_PERF_CNT_EN defined: the 16-bit saturating stallCount register is built as described above.
- HAZARD_PERF_CNT_EN undefined: no counter flops are built and stallCount is tied to 16'd0. All other behaviour is identical.

## Test plan
- Load-use: MemReadIDEX=1, RtIDEX=5, Rs=5 -> one cycle with pcWrite=0, IFIDWrite=0, bubbleIDEX=1. Repeat with RtIDEX=0 -> no stall.
- Rt gating: RtIDEX=7, Rt=7, Rs=3, usesRt=0 -> no stall. Same with usesRt=1 -> stall.
- Mult/div: MD_CYCLES=4, mdStart pulse at edge T -> busy=1 and bubbleIDEX=1 for exactly 3 cycles. branchTaken=1 during busy -> IFIDFlush stays 0.
- Branch: branchTaken=1 with no hazard -> IFIDFlush=1 for one cycle, pcWrite=1. Branch coincident with loadUse -> stall and no flush.
- Reset mid-busy: rst=0 on the second busy cycle -> next cycle state IDLE, busy=0, stallCount=0. While rst is low, bubbleIDEX=1 and pcWrite=0.
- Counter (HAZARD_PERF_CNT_EN): 3 load-use stalls plus one MD_CYCLES=4 occupancy -> stallCount=6. Preload near 16'hFFFF -> holds at 16'hFFFF. With the macro undefined -> always 0.
